// File: rtl/fetch_pkg.sv
// Shared types and helpers for the IF stage: fetch state encoding, the queued
// {pc, instr} entry and the fetch-address legality check.
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word aligned and the whole 4-byte word lies inside instruction memory.
  function automatic logic pc_is_legal(input logic [ADDR_W-1:0] pc,
                                       input logic [ADDR_W-1:0] imem_size);
    return (pc[1:0] == 2'b00) && ((pc + ADDR_W'(3)) < imem_size);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries between IF and ID. Flush wins over push/pop;
// the head is read straight from registered storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(QDEPTH);

  fetch_entry_t     mem_q [QDEPTH];
  fetch_entry_t     mem_d [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(QDEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(QDEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage next-state; push while full needs a pop.
  always_comb begin
    push_ok_s = push & (~full | pop);
    pop_ok_s  = pop & ~empty;
    mem_d     = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = wdata;
      end else begin
        mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches from instruction memory into a small queue,
// services redirects and halts on an illegal fetch address.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDR_W    = fetch_pkg::ADDR_W,
  parameter int                       IMEM_SIZE = 1024,
  parameter logic [fetch_pkg::ADDR_W-1:0] RESET_PC = '0,
  parameter int                       QDEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);

  localparam int          CNT_W   = $clog2(QDEPTH + 1);
  localparam logic [0:0]  ST_RUN  = RUN;
  localparam logic [0:0]  ST_HALT = HALT;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [0:0]        state_q, state_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

  logic              legal_s;
  logic              pop_s;
  logic              fetch_s;
  logic              push_s;
  fetch_entry_t      wdata_s;
  fetch_entry_t      head_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              empty_s;

  assign imem_addr = pc_q;
  assign id_valid  = (count_s != '0);
  assign id_pc     = head_s.pc;
  assign id_instr  = head_s.instr;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

  // Fetch/pop qualification; memory data is masked so an illegal PC never loads X.
  always_comb begin
    legal_s       = pc_is_legal(pc_q, ADDR_W'(IMEM_SIZE));
    pop_s         = ~empty_s & id_ready & ~redirect;
    fetch_s       = (state_q == ST_RUN) & ~redirect & (~full_s | pop_s);
    push_s        = fetch_s & legal_s;
    wdata_s.pc    = pc_q;
    wdata_s.instr = legal_s ? imem_instr : 32'h0000_0000;
  end

  // PC / halt state next-state; redirect overrides everything.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
      fault_d = 1'b0;
    end else if (fetch_s) begin
      if (legal_s) begin
        pc_d = pc_q + ADDR_W'(4);
      end else begin
        fault_d    = 1'b1;
        fault_pc_d = pc_q;
        state_d    = ST_HALT;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_RUN;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (redirect),
    .wdata   (wdata_s),
    .head    (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure, redirect,
// end-of-memory halt, misaligned redirect and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        fault;
  logic [63:0] fault_pc;

  logic [31:0] imem [256];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 64'd1024) ? imem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  fetch_unit #(
    .ADDR_W    (64),
    .IMEM_SIZE (1024),
    .RESET_PC  (64'd0),
    .QDEPTH    (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .fault       (fault),
    .fault_pc    (fault_pc)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
    redirect_pc = 64'd0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hC0DE_0000 + i;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    id_ready    = 1'b1;
    step();
    step();
    check("rst_valid", {63'd0, id_valid}, 64'd0);
    check("rst_pc", id_pc, 64'd0);
    check("rst_instr", {32'd0, id_instr}, 64'd0);
    check("rst_fault", {63'd0, fault}, 64'd0);
    check("rst_fault_pc", fault_pc, 64'd0);
    check("rst_addr", imem_addr, 64'd0);

    // 1: streaming from reset
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_valid", {63'd0, id_valid}, 64'd1);
      check("t1_pc", id_pc, 64'(k * 4));
      check("t1_instr", {32'd0, id_instr}, {32'd0, 32'hC0DE_0000 + 32'(k)});
    end

    // 2: back-pressure
    id_ready = 1'b0;
    apply_reset();
    repeat (5) step();
    check("t2_valid", {63'd0, id_valid}, 64'd1);
    check("t2_hold_pc", id_pc, 64'd0);
    check("t2_hold_instr", {32'd0, id_instr}, 64'hC0DE_0000);
    check("t2_addr", imem_addr, 64'd8);
    id_ready = 1'b1;
    step();
    check("t2_pc4", id_pc, 64'd4);
    check("t2_instr4", {32'd0, id_instr}, 64'hC0DE_0001);
    step();
    check("t2_pc8", id_pc, 64'd8);
    check("t2_instr8", {32'd0, id_instr}, 64'hC0DE_0002);

    // 3: redirect with a full queue
    id_ready = 1'b0;
    apply_reset();
    step();
    step();
    do_redirect(64'h40);
    check("t3_bubble", {63'd0, id_valid}, 64'd0);
    check("t3_addr", imem_addr, 64'h40);
    step();
    check("t3_valid", {63'd0, id_valid}, 64'd1);
    check("t3_pc", id_pc, 64'h40);
    check("t3_instr", {32'd0, id_instr}, 64'hC0DE_0010);

    // 4: run off the end of memory, then recover
    id_ready = 1'b1;
    do_redirect(64'h3F8);
    step();
    check("t4_pc3f8", id_pc, 64'h3F8);
    check("t4_instr3f8", {32'd0, id_instr}, 64'hC0DE_00FE);
    step();
    check("t4_pc3fc", id_pc, 64'h3FC);
    check("t4_instr3fc", {32'd0, id_instr}, 64'hC0DE_00FF);
    step();
    check("t4_fault", {63'd0, fault}, 64'd1);
    check("t4_fault_pc", fault_pc, 64'h400);
    check("t4_no_valid", {63'd0, id_valid}, 64'd0);
    check("t4_addr", imem_addr, 64'h400);
    repeat (3) step();
    check("t4_frozen_addr", imem_addr, 64'h400);
    check("t4_frozen_valid", {63'd0, id_valid}, 64'd0);
    do_redirect(64'd0);
    check("t4_clear", {63'd0, fault}, 64'd0);
    check("t4_keep_fault_pc", fault_pc, 64'h400);
    check("t4_resume_addr", imem_addr, 64'd0);
    step();
    check("t4_resume_pc", id_pc, 64'd0);
    check("t4_resume_valid", {63'd0, id_valid}, 64'd1);

    // 5: misaligned redirect
    do_redirect(64'h42);
    check("t5_pre_fault", {63'd0, fault}, 64'd0);
    step();
    check("t5_fault", {63'd0, fault}, 64'd1);
    check("t5_fault_pc", fault_pc, 64'h42);
    check("t5_no_valid", {63'd0, id_valid}, 64'd0);

    // 6: asynchronous reset mid-cycle with two entries queued
    id_ready = 1'b0;
    do_redirect(64'h20);
    step();
    step();
    check("t6_pre_valid", {63'd0, id_valid}, 64'd1);
    check("t6_pre_pc", id_pc, 64'h20);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid", {63'd0, id_valid}, 64'd0);
    check("t6_fault", {63'd0, fault}, 64'd0);
    check("t6_addr", imem_addr, 64'd0);
    check("t6_pc", id_pc, 64'd0);
    check("t6_instr", {32'd0, id_instr}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
